// File: rtl/demux_striping_n_pkg.sv
// Shared defaults and legal parameter ranges for the striping demux and its
// matching unstriping block.
package demux_striping_n_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned MIN_DATA_W = 8;
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MIN_LANES  = 2;
  localparam int unsigned MAX_LANES  = 8;

  function automatic bit params_legal(input int unsigned data_w, input int unsigned lanes);
    return (data_w >= MIN_DATA_W) && (data_w <= MAX_DATA_W) &&
           (lanes >= MIN_LANES) && (lanes <= MAX_LANES);
  endfunction

endpackage

// File: rtl/stripe_lane_pick.sv
// Circular priority finder: first enabled lane at or after start, wrapping,
// and whether that lane is the highest-indexed enabled one.
module stripe_lane_pick #(
  parameter int unsigned LANES = 4,
  parameter int unsigned PTR_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] lane_en,
  input  logic [PTR_W-1:0] start,
  output logic [PTR_W-1:0] target_c,
  output logic             found_c,
  output logic             is_last_c
);

  int idx;
  int tgt;
  int hi;

  always_comb begin
    idx       = 0;
    tgt       = -1;
    hi        = -1;
    target_c  = '0;
    found_c   = 1'b0;
    is_last_c = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_en[PTR_W'(i)]) hi = i;
    end
    // Walk from the farthest offset back so the nearest enabled lane wins.
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= int'(LANES)) idx = idx - int'(LANES);
      if (lane_en[PTR_W'(idx)]) tgt = idx;
    end
    if (tgt >= 0) begin
      target_c  = PTR_W'(tgt);
      found_c   = 1'b1;
      is_last_c = (tgt == hi);
    end
  end

endmodule

// File: rtl/demux_striping_n.sv
// Round-robin word striping across LANES output lanes with runtime lane mask,
// resync to lane 0, round-complete and drop-error pulses.
module demux_striping_n
  import demux_striping_n_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES
) (
  input  logic                    clk_2f,
  input  logic                    reset_L,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    sync,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out,
  output logic                    round_done,
  output logic                    drop_err
);

  localparam int unsigned PTR_W = $clog2(LANES);

  if (!params_legal(DATA_W, LANES)) begin : g_param_err
    $error("demux_striping_n: DATA_W must be 8..64 and LANES 2..8");
  end

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] start_c;
  logic [PTR_W-1:0] target_c;
  logic             found_c;
  logic             is_last_c;
  logic             beat_c;

  assign start_c = sync ? '0 : ptr;
  assign beat_c  = valid_in & found_c;

  stripe_lane_pick #(
    .LANES (LANES),
    .PTR_W (PTR_W)
  ) u_pick (
    .lane_en   (lane_en),
    .start     (start_c),
    .target_c  (target_c),
    .found_c   (found_c),
    .is_last_c (is_last_c)
  );

  // Non-target lane slices keep their last word; only the qualifiers pulse.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      ptr        <= '0;
      data_out   <= '0;
      valid_out  <= '0;
      round_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      valid_out  <= beat_c ? (LANES'(1) << target_c) : '0;
      round_done <= beat_c & is_last_c;
      drop_err   <= valid_in & ~found_c;
      if (beat_c) begin
        data_out[int'(target_c) * int'(DATA_W) +: DATA_W] <= data_in;
        ptr <= (target_c == PTR_W'(LANES - 1)) ? '0 : target_c + PTR_W'(1);
      end else if (sync) begin
        ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_demux_striping_n.sv
// Scoreboard bench for demux_striping_n: directed scenarios then random traffic,
// checked against a lane-array reference model.
module tb_demux_striping_n;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef struct {
    logic [LANES-1:0]        vo;
    logic [LANES*DATA_W-1:0] dat;
    logic                    rd;
    logic                    de;
  } exp_t;

  logic                    clk_2f = 1'b0;
  logic                    reset_L;
  logic                    valid_in;
  logic [DATA_W-1:0]       data_in;
  logic [LANES-1:0]        lane_en;
  logic                    sync;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic                    round_done;
  logic                    drop_err;

  exp_t              q[$];
  exp_t              mon_e;
  int                checks   = 0;
  int                failures = 0;
  int                m_ptr    = 0;
  logic [DATA_W-1:0] m_data [LANES];

  demux_striping_n #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .lane_en    (lane_en),
    .sync       (sync),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .round_done (round_done),
    .drop_err   (drop_err)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [LANES*DATA_W-1:0] pack_model();
    logic [LANES*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(LANES); i++) v[i*DATA_W +: DATA_W] = m_data[i];
    return v;
  endfunction

  // Apply one cycle of inputs and queue what the lanes should show next cycle.
  task automatic drive(input bit v, input logic [DATA_W-1:0] d,
                       input logic [LANES-1:0] en, input bit s);
    int   start;
    int   tgt;
    int   hi;
    exp_t e;
    @(negedge clk_2f);
    valid_in = v;
    data_in  = d;
    lane_en  = en;
    sync     = s;
    start = s ? 0 : m_ptr;
    tgt   = -1;
    hi    = -1;
    for (int k = 0; k < int'(LANES); k++) begin
      int i;
      i = (start + k) % int'(LANES);
      if (tgt < 0 && en[i]) tgt = i;
    end
    for (int i = 0; i < int'(LANES); i++) if (en[i]) hi = i;
    if (v && tgt >= 0) begin
      m_data[tgt] = d;
      e.vo  = LANES'(1) << tgt;
      e.dat = pack_model();
      e.rd  = (tgt == hi);
      e.de  = 1'b0;
      q.push_back(e);
      m_ptr = (tgt + 1) % int'(LANES);
    end else begin
      if (v) begin
        e.vo  = '0;
        e.dat = pack_model();
        e.rd  = 1'b0;
        e.de  = 1'b1;
        q.push_back(e);
      end
      if (s) m_ptr = 0;
    end
  endtask

  // Monitor: every visible output event must match the oldest queued beat.
  always @(posedge clk_2f) begin
    #1;
    if (reset_L && (valid_out != '0 || drop_err || round_done)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output valid_out=%0h round_done=%0b drop_err=%0b required=none",
                 valid_out, round_done, drop_err);
      end else begin
        mon_e = q.pop_front();
        chk("valid_out", 256'(valid_out), 256'(mon_e.vo));
        chk("data_out", 256'(data_out), 256'(mon_e.dat));
        chk("round_done", 256'(round_done), 256'(mon_e.rd));
        chk("drop_err", 256'(drop_err), 256'(mon_e.de));
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_valid_out"}, 256'(valid_out), 256'(0));
    chk({tag, "_data_out"}, 256'(data_out), 256'(0));
    chk({tag, "_round_done"}, 256'(round_done), 256'(0));
    chk({tag, "_drop_err"}, 256'(drop_err), 256'(0));
  endtask

  initial begin
    for (int i = 0; i < int'(LANES); i++) m_data[i] = '0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    lane_en  = '0;
    sync     = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk_2f);
    reset_L = 1'b1;

    // All lanes enabled: plain round robin.
    for (int i = 0; i < 8; i++) drive(1'b1, DATA_W'(32'hA0 + i), 4'hF, 1'b0);
    drive(1'b0, '0, 4'hF, 1'b0);
    // Sparse mask: lanes 1 and 3 only.
    for (int i = 0; i < 4; i++) drive(1'b1, DATA_W'(32'h10 + i), 4'b1010, 1'b0);
    // No lane enabled: beat dropped, pointer kept.
    drive(1'b1, DATA_W'(32'h55), 4'b0000, 1'b0);
    drive(1'b0, '0, 4'hF, 1'b0);
    // Resync mid-round.
    drive(1'b1, DATA_W'(32'h20), 4'hF, 1'b0);
    drive(1'b1, DATA_W'(32'h21), 4'hF, 1'b0);
    drive(1'b1, DATA_W'(32'h77), 4'hF, 1'b1);
    drive(1'b1, DATA_W'(32'h78), 4'hF, 1'b0);
    // Pointed lane 2 disabled on the same cycle.
    drive(1'b1, DATA_W'(32'h99), 4'b1011, 1'b0);
    // Sync on an idle cycle.
    drive(1'b0, '0, 4'hF, 1'b1);
    drive(1'b1, DATA_W'(32'h30), 4'hF, 1'b0);

    // Reset between two valid beats: the second one is lost.
    drive(1'b1, DATA_W'(32'h40), 4'hF, 1'b0);
    drive(1'b1, DATA_W'(32'h41), 4'hF, 1'b0);
    #2;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    void'(q.pop_back());
    m_ptr = 0;
    for (int i = 0; i < int'(LANES); i++) m_data[i] = '0;
    #1;
    check_cleared("midreset");
    @(negedge clk_2f);
    reset_L = 1'b1;
    drive(1'b1, DATA_W'(32'h42), 4'hF, 1'b0);

    for (int n = 0; n < 400; n++) begin
      int               r;
      logic [LANES-1:0] en;
      r  = int'($urandom_range(0, 9));
      en = (r == 0) ? '0 : (r == 1) ? 4'hF : LANES'($urandom);
      drive($urandom_range(0, 3) != 0, DATA_W'($urandom), en, $urandom_range(0, 15) == 0);
    end
    drive(1'b0, '0, 4'hF, 1'b0);
    repeat (3) @(negedge clk_2f);
    chk("pending_beats", 256'(q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
